// File: rtl/sfu_requant.sv
// Requantization unit: accumulates a configurable number of signed psum vectors per lane,
// then shifts, clamps (signed or ReLU) and presents one bw-bit activation per lane.
module sfu_requant #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int acc_bw  = psum_bw + 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*psum_bw-1:0] in_psum,
  input  logic [3:0]             acc_len,
  input  logic [3:0]             shift,
  input  logic                   relu_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*bw-1:0]      out_act,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

  localparam logic signed [acc_bw-1:0] u_max = acc_bw'((1 << bw) - 1);
  localparam logic signed [acc_bw-1:0] s_max = acc_bw'((1 << (bw - 1)) - 1);
  localparam logic signed [acc_bw-1:0] s_min = ~s_max;

  state_t                    state;
  logic [3:0]                cnt;
  logic [3:0]                len_q;
  logic [3:0]                shift_q;
  logic                      relu_q;
  logic signed [acc_bw-1:0]  acc [col];
  logic signed [acc_bw-1:0]  ext [col];
  logic signed [acc_bw-1:0]  sum [col];
  logic [col*bw-1:0]         q_first;
  logic [col*bw-1:0]         q_next;
  logic [3:0]                eff_len;
  logic [3:0]                cnt_next;

  // Arithmetic shift floors toward minus infinity; the clamp then saturates to the output range.
  function automatic logic [bw-1:0] requant(input logic signed [acc_bw-1:0] a,
                                            input logic [3:0] sh, input logic relu);
    logic signed [acc_bw-1:0] s;
    s = a >>> sh;
    if (relu) begin
      if (s[acc_bw-1])   return '0;
      else if (s > u_max) return u_max[bw-1:0];
      else                return s[bw-1:0];
    end else begin
      if (s > s_max)      return s_max[bw-1:0];
      else if (s < s_min) return s_min[bw-1:0];
      else                return s[bw-1:0];
    end
  endfunction

  always_comb begin
    logic signed [psum_bw-1:0] lane;
    lane     = '0;
    q_first  = '0;
    q_next   = '0;
    eff_len  = (acc_len == 4'd0) ? 4'd1 : acc_len;
    cnt_next = cnt + 4'd1;
    for (int i = 0; i < col; i++) begin
      lane   = in_psum[i*psum_bw +: psum_bw];
      ext[i] = acc_bw'(lane);
      sum[i] = acc[i] + ext[i];
      q_first[i*bw +: bw] = requant(ext[i], shift, relu_en);
      q_next[i*bw +: bw]  = requant(sum[i], shift_q, relu_q);
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is low only in OUT, out_valid is high only in OUT.
  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      out_act <= '0;
      for (int i = 0; i < col; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          len_q   <= eff_len;
          shift_q <= shift;
          relu_q  <= relu_en;
          cnt     <= 4'd1;
          for (int i = 0; i < col; i++) acc[i] <= ext[i];
          if (eff_len == 4'd1) begin
            out_act <= q_first;
            state   <= OUT;
          end else begin
            state   <= ACC;
          end
        end
        ACC: if (in_valid) begin
          cnt <= cnt_next;
          for (int i = 0; i < col; i++) acc[i] <= sum[i];
          if (cnt_next == len_q) begin
            out_act <= q_next;
            state   <= OUT;
          end
        end
        OUT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfu_requant.sv
// Directed bench for sfu_requant: table of single-group vectors plus hand sequences for
// backpressure, reset mid-group and 15-beat accumulation headroom.
module tb_sfu_requant;

  localparam int bw      = 4;
  localparam int psum_bw = 16;
  localparam int col     = 8;
  localparam int pw      = col * psum_bw;
  localparam int ow      = col * bw;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [pw-1:0] in_psum;
  logic [3:0]    acc_len;
  logic [3:0]    shift;
  logic          relu_en;
  logic          out_valid;
  logic          out_ready;
  logic [ow-1:0] out_act;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [ow-1:0] exp_q[$];
  int            n_pass  = 0;
  int            n_total = 0;

  sfu_requant #(.bw(bw), .psum_bw(psum_bw), .col(col)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .acc_len(acc_len), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]         len;
    logic [3:0]         sh;
    logic               relu;
    int                 gap;
    logic [2:0][pw-1:0] beat;
    logic [ow-1:0]      exp_act;
  } vec_t;

  function automatic logic [pw-1:0] pk(input int a, input int b, input int c, input int d);
    logic [pw-1:0] v;
    v = '0;
    v[0*psum_bw +: psum_bw] = psum_bw'(a);
    v[1*psum_bw +: psum_bw] = psum_bw'(b);
    v[2*psum_bw +: psum_bw] = psum_bw'(c);
    v[3*psum_bw +: psum_bw] = psum_bw'(d);
    return v;
  endfunction

  function automatic logic [ow-1:0] po(input int a, input int b, input int c, input int d);
    logic [ow-1:0] v;
    v = '0;
    v[0*bw +: bw] = bw'(a);
    v[1*bw +: bw] = bw'(b);
    v[2*bw +: bw] = bw'(c);
    v[3*bw +: bw] = bw'(d);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
  endtask

  task automatic drive_beat(input logic [pw-1:0] p, input logic [3:0] len,
                            input logic [3:0] sh, input logic r);
    int budget;
    @(negedge clk);
    in_valid = 1'b1;
    in_psum  = p;
    acc_len  = len;
    shift    = sh;
    relu_en  = r;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    logic [ow-1:0] e;
    e = '0;
    if (exp_q.size() == 0) check({name, "_queue_empty"}, 64'd0, 64'd1);
    else e = exp_q.pop_front();
    check({name, "_out_valid"}, 64'(out_valid), 64'd1);
    check({name, "_out_act"}, 64'(out_act), 64'(e));
    check({name, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_idle"}, 64'(dbg_state), 64'd0);
    check({name, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{len: 4'd3, sh: 4'd2, relu: 1'b1, gap: 2,
                beat: {pk(-4, -1, 30000, 0), pk(20, -1, 30000, 0), pk(10, -100, 30000, 0)},
                exp_act: po(6, 0, 15, 0)};
    vecs[1] = '{len: 4'd1, sh: 4'd0, relu: 1'b0, gap: 0,
                beat: {pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(-5, -20, 7, 100)},
                exp_act: po(4'hB, 4'h8, 4'h7, 4'h7)};
    vecs[2] = '{len: 4'd1, sh: 4'd1, relu: 1'b0, gap: 0,
                beat: {pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(-5, 0, 0, 0)},
                exp_act: po(4'hD, 0, 0, 0)};
    vecs[3] = '{len: 4'd0, sh: 4'd0, relu: 1'b1, gap: 0,
                beat: {pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(5, 0, 0, 0)},
                exp_act: po(5, 0, 0, 0)};
    vecs[4] = '{len: 4'd2, sh: 4'd3, relu: 1'b0, gap: 1,
                beat: {pk(0, 0, 0, 0), pk(-9, 15, 0, 100), pk(-40, 16, -1, 100)},
                exp_act: po(4'h9, 3, 4'hF, 7)};
    vecs[5] = '{len: 4'd2, sh: 4'd4, relu: 1'b1, gap: 0,
                beat: {pk(0, 0, 0, 0), pk(140, 0, 0, 16), pk(100, 256, -17, 15)},
                exp_act: po(15, 15, 0, 1)};

    reset = 1'b1; in_valid = 1'b0; in_psum = '0; acc_len = '0; shift = '0;
    relu_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_act", 64'(out_act), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table: config inputs are scrambled after the first beat to prove they were latched.
    for (int v = 0; v < 6; v++) begin
      int n;
      n = (vecs[v].len == 4'd0) ? 1 : int'(vecs[v].len);
      exp_q.push_back(vecs[v].exp_act);
      for (int b = 0; b < n; b++) begin
        if (b == 0) drive_beat(vecs[v].beat[b], vecs[v].len, vecs[v].sh, vecs[v].relu);
        else drive_beat(vecs[v].beat[b], vecs[v].len ^ 4'hF, vecs[v].sh ^ 4'h5, ~vecs[v].relu);
        if (b < n - 1) begin
          check($sformatf("v%0d_mid_valid", v), 64'(out_valid), 64'd0);
          repeat (vecs[v].gap) begin
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gap_hold", v), 64'({out_valid, busy, dbg_state}), 64'b1_01);
          end
        end
      end
      collect($sformatf("v%0d", v));
    end

    // 15 max-magnitude psums must not wrap.
    exp_q.push_back(po(14, 8, 0, 0));
    for (int b = 0; b < 15; b++) drive_beat(pk(32767, -32768, 0, 0), 4'd15, 4'd15, b == 0);
    exp_q[0] = po(14, 0, 0, 0);
    collect("acc15_relu");
    exp_q.push_back(po(7, 4'h8, 0, 0));
    for (int b = 0; b < 15; b++) drive_beat(pk(32767, -32768, 0, 0), 4'd15, 4'd15, 1'b0);
    collect("acc15_signed");

    // Backpressure: output held, no psum consumed while in OUT.
    exp_q.push_back(po(3, 0, 0, 0));
    drive_beat(pk(3, 0, 0, 0), 4'd1, 4'd0, 1'b1);
    in_valid = 1'b1;
    in_psum  = pk(7, 7, 7, 7);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_out_act", 64'(out_act), 64'(exp_q[0]));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_idle", 64'(dbg_state), 64'd0);

    // Reset mid-group discards the partial accumulation.
    drive_beat(pk(100, 100, 0, 0), 4'd3, 4'd0, 1'b1);
    drive_beat(pk(100, 100, 0, 0), 4'd3, 4'd0, 1'b1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({out_valid, busy, dbg_state}), 64'd0);
    check("mid_rst_out_act", 64'(out_act), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(po(9, 0, 0, 0));
    drive_beat(pk(9, 0, 0, 0), 4'd1, 4'd0, 1'b1);
    collect("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
